// File: rtl/dds_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel DDS.
// The sine helper is evaluated at elaboration only, to build the ROM constants.
package dds_pkg;

    typedef enum logic [1:0] {
        FCW      = 2'd0,
        OFFSET   = 2'd1,
        AMP      = 2'd2,
        ACC_LOAD = 2'd3
    } cfg_sel_e;

    localparam real PI = 3.14159265358979323846;

    // Channel index width; a single channel still gets a 1-bit tag.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sine_val(input int k, input int lut_aw, input int sig_w);
        real ang;
        real x;
        ang = 2.0 * PI * $itor(k) / (2.0 ** lut_aw);
        x   = $sin(ang) * ((2.0 ** (sig_w - 1)) - 1.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

endpackage

// File: rtl/dds_mc_if.sv
// Config write port and sample output stream of the multi-channel DDS.
interface dds_mc_if #(
    parameter int N_CH    = 4,
    parameter int PHASE_W = 24,
    parameter int SIG_W   = 16
);
    import dds_pkg::*;

    localparam int CH_W = ch_width(N_CH);

    logic                    i_cfg_we;
    logic [CH_W-1:0]         i_cfg_ch;
    cfg_sel_e                i_cfg_sel;
    logic [PHASE_W-1:0]      i_cfg_data;

    // Stream: a sample transfers on an edge where o_valid && i_ready; while
    // o_valid && !i_ready, o_valid/o_ch/o_sample hold unchanged.
    logic                    o_valid;
    logic                    i_ready;
    logic [CH_W-1:0]         o_ch;
    logic signed [SIG_W-1:0] o_sample;

    modport master (
        output i_cfg_we, i_cfg_ch, i_cfg_sel, i_cfg_data, i_ready,
        input  o_valid, o_ch, o_sample
    );

    modport slave (
        input  i_cfg_we, i_cfg_ch, i_cfg_sel, i_cfg_data, i_ready,
        output o_valid, o_ch, o_sample
    );

endinterface

// File: rtl/dds_sine_rom.sv
// Full-wave sine lookup built from a quarter-wave table, registered output.
// Holds on !i_en so it can sit inside a stallable pipeline.
module dds_sine_rom
    import dds_pkg::*;
#(
    parameter int LUT_AW = 10,
    parameter int SIG_W  = 16
) (
    input  logic                    clk,
    input  logic                    a_rst_n,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic [LUT_AW-1:0]       i_addr,
    output logic signed [SIG_W-1:0] o_data
);
    localparam int Q = 1 << (LUT_AW - 2);

    // Endpoint entry Q is kept so quadrant 1 at index 0 reads the true peak.
    logic signed [SIG_W-1:0] qtab [Q+1];

    for (genvar i = 0; i <= Q; i++) begin : g_tab
        localparam logic signed [SIG_W-1:0] V = SIG_W'(sine_val(i, LUT_AW, SIG_W));
        assign qtab[i] = V;
    end

    logic [1:0]              quad;
    logic [LUT_AW-3:0]       idx;
    logic [LUT_AW-2:0]       tidx;
    logic signed [SIG_W-1:0] mag;
    logic signed [SIG_W-1:0] val;

    always_comb begin
        quad = i_addr[LUT_AW-1 -: 2];
        idx  = i_addr[LUT_AW-3:0];
        tidx = quad[0] ? ((LUT_AW-1)'(Q) - {1'b0, idx}) : {1'b0, idx};
        mag  = qtab[tidx];
        val  = quad[1] ? -mag : mag;
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            o_data <= '0;
        end else if (i_clr) begin
            o_data <= '0;
        end else if (i_en) begin
            o_data <= val;
        end
    end

endmodule

// File: rtl/dds_mc.sv
// Time-multiplexed multi-channel DDS: round-robin phase accumulators feeding a
// shared sine ROM and amplitude multiplier, emitted as a valid/ready stream.
module dds_mc
    import dds_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 10,
    parameter int SIG_W   = 16,
    parameter int AMP_W   = 16
) (
    input logic     clk,
    input logic     a_rst_n,
    input logic     i_sync_rst,
    input logic     i_run,
    dds_mc_if.slave bus
);
    localparam int                CH_W    = ch_width(N_CH);
    localparam int                PW      = SIG_W + AMP_W + 1;
    localparam logic [CH_W:0]     N_CH_V  = (CH_W + 1)'(N_CH);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);

    logic [PHASE_W-1:0] acc [N_CH];
    logic [PHASE_W-1:0] fcw [N_CH];
    logic [PHASE_W-1:0] off [N_CH];
    logic [AMP_W-1:0]   amp [N_CH];

    logic [CH_W-1:0]         ch_q, ch0, ch1;
    logic                    v0, v1;
    logic [LUT_AW-1:0]       p0;
    logic signed [SIG_W-1:0] s1;
    logic signed [PW-1:0]    s1_x, amp_x, prod;

    logic adv, issue, cfg_wr, ld_hit;

    assign adv    = !(bus.o_valid && !bus.i_ready);
    assign issue  = i_run && adv;
    // Soft clear swallows a same-cycle write; unused tags of a non-power-of-two
    // channel count are ignored.
    assign cfg_wr = bus.i_cfg_we && !i_sync_rst && ({1'b0, bus.i_cfg_ch} < N_CH_V);
    assign ld_hit = cfg_wr && (bus.i_cfg_sel == ACC_LOAD);

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                fcw[c] <= '0;
                off[c] <= '0;
                amp[c] <= '0;
            end
        end else if (cfg_wr) begin
            case (bus.i_cfg_sel)
                FCW:     fcw[bus.i_cfg_ch] <= bus.i_cfg_data;
                OFFSET:  off[bus.i_cfg_ch] <= bus.i_cfg_data;
                AMP:     amp[bus.i_cfg_ch] <= AMP_W'(bus.i_cfg_data);
                default: ;
            endcase
        end
    end

    // A runtime load beats the same-cycle increment of that channel.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int c = 0; c < N_CH; c++) acc[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (i_sync_rst) begin
                    acc[c] <= '0;
                end else if (ld_hit && (bus.i_cfg_ch == CH_W'(c))) begin
                    acc[c] <= bus.i_cfg_data;
                end else if (issue && (ch_q == CH_W'(c))) begin
                    acc[c] <= acc[c] + fcw[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            ch_q <= '0;
            p0   <= '0;
            ch0  <= '0;
            v0   <= 1'b0;
            ch1  <= '0;
            v1   <= 1'b0;
        end else if (i_sync_rst) begin
            ch_q <= '0;
            p0   <= '0;
            ch0  <= '0;
            v0   <= 1'b0;
            ch1  <= '0;
            v1   <= 1'b0;
        end else begin
            if (issue) begin
                ch_q <= (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
            end
            if (adv) begin
                v0  <= i_run;
                v1  <= v0;
                ch1 <= ch0;
                if (i_run) begin
                    // Only the top LUT_AW bits of the pre-increment phase are kept.
                    p0  <= LUT_AW'((acc[ch_q] + off[ch_q]) >> (PHASE_W - LUT_AW));
                    ch0 <= ch_q;
                end
            end
        end
    end

    dds_sine_rom #(
        .LUT_AW (LUT_AW),
        .SIG_W  (SIG_W)
    ) u_rom (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .i_en    (adv),
        .i_clr   (i_sync_rst),
        .i_addr  (p0),
        .o_data  (s1)
    );

    // Amplitude is read at this stage, so a change applies to samples still in flight.
    assign s1_x  = {{(AMP_W + 1){s1[SIG_W-1]}}, s1};
    assign amp_x = {{SIG_W{1'b0}}, 1'b0, amp[ch1]};
    assign prod  = s1_x * amp_x;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            bus.o_valid  <= 1'b0;
            bus.o_ch     <= '0;
            bus.o_sample <= '0;
        end else if (i_sync_rst) begin
            bus.o_valid  <= 1'b0;
            bus.o_ch     <= '0;
            bus.o_sample <= '0;
        end else if (adv) begin
            bus.o_valid  <= v1;
            bus.o_ch     <= ch1;
            bus.o_sample <= SIG_W'(prod >>> AMP_W);
        end
    end

endmodule

// File: tb/tb_dds_mc.sv
// Directed bench for dds_mc: a transaction model pushes expected samples at
// issue time and the stream monitor pops them on each transfer.
module tb_dds_mc;
    import dds_pkg::*;

    localparam int N_CH    = 4;
    localparam int PHASE_W = 24;
    localparam int LUT_AW  = 10;
    localparam int SIG_W   = 16;
    localparam int AMP_W   = 16;
    localparam int CH_W    = 2;

    logic clk        = 1'b0;
    logic a_rst_n    = 1'b0;
    logic i_sync_rst = 1'b0;
    logic i_run      = 1'b0;

    dds_mc_if #(.N_CH(N_CH), .PHASE_W(PHASE_W), .SIG_W(SIG_W)) bus ();

    dds_mc #(
        .N_CH    (N_CH),
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW),
        .SIG_W   (SIG_W),
        .AMP_W   (AMP_W)
    ) dut (
        .clk        (clk),
        .a_rst_n    (a_rst_n),
        .i_sync_rst (i_sync_rst),
        .i_run      (i_run),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [CH_W+SIG_W-1:0] exp_q [$];

    logic [PHASE_W-1:0] m_acc [N_CH];
    logic [PHASE_W-1:0] m_fcw [N_CH];
    logic [PHASE_W-1:0] m_off [N_CH];
    logic [AMP_W-1:0]   m_amp [N_CH];
    logic [CH_W-1:0]    m_ch_q;
    logic               m_v0, m_v1, m_vo;

    logic                    prev_stall;
    logic [CH_W-1:0]         prev_ch;
    logic signed [SIG_W-1:0] prev_sample;

    logic signed [SIG_W-1:0] log0 [$];
    logic signed [SIG_W-1:0] log1 [$];
    logic signed [SIG_W-1:0] log2 [$];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [SIG_W-1:0] exp_sample(input logic [PHASE_W-1:0] ph,
                                                           input logic [AMP_W-1:0] a);
        int     k;
        real    x;
        int     s;
        longint p;
        k = int'(ph >> (PHASE_W - LUT_AW));
        x = $sin(2.0 * 3.14159265358979323846 * $itor(k) / $itor(1 << LUT_AW)) * 32767.0;
        s = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        p = longint'(s) * longint'(a);
        return SIG_W'(p >>> AMP_W);
    endfunction

    // One clock: monitor the stream, advance the model, then cross the edge.
    task automatic step();
        logic                  m_adv;
        logic                  m_issue;
        logic [CH_W+SIG_W-1:0] e;
        m_adv   = !(m_vo && !bus.i_ready);
        m_issue = i_run && m_adv;

        check("o_valid", bus.o_valid, m_vo);
        if (prev_stall) begin
            check("stall_ch", bus.o_ch, prev_ch);
            check("stall_sample", bus.o_sample, prev_sample);
        end
        if (bus.o_valid && bus.i_ready) begin
            check("exp_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("o_ch", bus.o_ch, e[SIG_W +: CH_W]);
                check("o_sample", bus.o_sample, signed'(e[SIG_W-1:0]));
                if (bus.o_ch == 2'd0) log0.push_back(bus.o_sample);
                if (bus.o_ch == 2'd1) log1.push_back(bus.o_sample);
                if (bus.o_ch == 2'd2) log2.push_back(bus.o_sample);
            end
        end
        prev_stall  = bus.o_valid && !bus.i_ready;
        prev_ch     = bus.o_ch;
        prev_sample = bus.o_sample;

        if (i_sync_rst) begin
            exp_q.delete();
            for (int c = 0; c < N_CH; c++) m_acc[c] = '0;
            m_ch_q     = '0;
            m_v0       = 1'b0;
            m_v1       = 1'b0;
            m_vo       = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (m_issue) begin
                exp_q.push_back({m_ch_q, exp_sample(m_acc[m_ch_q] + m_off[m_ch_q], m_amp[m_ch_q])});
                m_acc[m_ch_q] = m_acc[m_ch_q] + m_fcw[m_ch_q];
            end
            if (bus.i_cfg_we) begin
                case (bus.i_cfg_sel)
                    FCW:      m_fcw[bus.i_cfg_ch] = bus.i_cfg_data;
                    OFFSET:   m_off[bus.i_cfg_ch] = bus.i_cfg_data;
                    AMP:      m_amp[bus.i_cfg_ch] = bus.i_cfg_data[AMP_W-1:0];
                    ACC_LOAD: m_acc[bus.i_cfg_ch] = bus.i_cfg_data;
                    default: ;
                endcase
            end
            if (m_adv) begin
                m_vo = m_v1;
                m_v1 = m_v0;
                m_v0 = m_issue;
            end
            if (m_issue) m_ch_q = (m_ch_q == CH_W'(N_CH - 1)) ? '0 : m_ch_q + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input int ch, input cfg_sel_e sel, input logic [PHASE_W-1:0] data);
        bus.i_cfg_we   = 1'b1;
        bus.i_cfg_ch   = CH_W'(ch);
        bus.i_cfg_sel  = sel;
        bus.i_cfg_data = data;
        step();
        bus.i_cfg_we   = 1'b0;
    endtask

    initial begin
        int guard;
        bus.i_cfg_we   = 1'b0;
        bus.i_cfg_ch   = '0;
        bus.i_cfg_sel  = FCW;
        bus.i_cfg_data = '0;
        bus.i_ready    = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            m_acc[c] = '0;
            m_fcw[c] = '0;
            m_off[c] = '0;
            m_amp[c] = '0;
        end
        m_ch_q      = '0;
        m_v0        = 1'b0;
        m_v1        = 1'b0;
        m_vo        = 1'b0;
        prev_stall  = 1'b0;
        prev_ch     = '0;
        prev_sample = '0;

        // Reset and zero configuration
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.o_valid, 0);
        check("rst_ch", bus.o_ch, 0);
        check("rst_sample", bus.o_sample, 0);
        a_rst_n = 1'b1;
        i_run   = 1'b1;
        run_cycles(12);
        check("zero_cfg_ch0", log0[0], 0);
        i_run = 1'b0;
        run_cycles(4);
        check("drained", exp_q.size(), 0);

        // Channel setup while idle
        cfg(0, FCW,    24'h400000);
        cfg(0, AMP,    24'h00FFFF);
        cfg(1, OFFSET, 24'h400000);
        cfg(1, AMP,    24'h008000);
        cfg(2, FCW,    24'h123456);
        cfg(2, OFFSET, 24'h200000);
        cfg(2, AMP,    24'h007000);
        cfg(3, FCW,    24'h0ABCDE);
        cfg(3, AMP,    24'h00C000);

        // Quarter-turn tone and fixed phase offset
        log0.delete();
        log1.delete();
        log2.delete();
        i_run = 1'b1;
        run_cycles(20);
        check("quarter_0", log0[0], 0);
        check("quarter_1", log0[1], 32766);
        check("quarter_2", log0[2], 0);
        check("quarter_3", log0[3], -32767);
        check("quarter_4", log0[4], 0);
        check("offset_0", log1[0], 16383);
        check("offset_2", log1[2], 16383);

        // Backpressure for 5 cycles
        bus.i_ready = 1'b0;
        run_cycles(5);
        bus.i_ready = 1'b1;
        run_cycles(8);

        // Soft clear mid-stream keeps configuration
        i_sync_rst = 1'b1;
        step();
        i_sync_rst = 1'b0;
        check("sync_valid", bus.o_valid, 0);
        check("sync_sample", bus.o_sample, 0);
        log0.delete();
        log1.delete();
        log2.delete();
        run_cycles(10);
        check("sync_ch0_phase", log0[0], 0);
        check("sync_ch1_off", log1[0], 16383);
        check("sync_ch2_off", log2[0], 10136);

        // Accumulator load colliding with the ch2 issue
        guard = 0;
        while (m_ch_q != 2'd2 && guard < 2 * N_CH) begin
            step();
            guard++;
        end
        check("ch2_issue_found", m_ch_q, 2);
        log2.delete();
        cfg(2, ACC_LOAD, 24'h800000);
        run_cycles(12);
        check("collision_next", log2[1], -10137);

        // Async reset mid-stream
        check("pre_arst_valid", bus.o_valid, 1);
        #2 a_rst_n = 1'b0;
        #1;
        check("arst_valid", bus.o_valid, 0);
        check("arst_ch", bus.o_ch, 0);
        check("arst_sample", bus.o_sample, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dds_mc.md
# dds_mc

Multi-channel, time-multiplexed direct digital synthesiser with per-channel phase accumulators. It generalises the single-tone DDS with parametrised phase, LUT, amplitude and channel widths, and adds runtime phase load, a synchronous soft clear and a valid/ready output stream. It sits between the AXI-Lite register bank, which drives the config port, and the downstream DAC/FIR stream.

## Interface
- `N_CH`, 4: channel count, ≥1; non-power-of-two allowed.
- `PHASE_W`, 24: accumulator, frequency word and offset width.
- `LUT_AW`, 10: full-wave sine resolution in address bits, ≥3.
- `SIG_W`, 16: signed sample width.
- `AMP_W`, 16: unsigned amplitude width.
- `clk` in, 1: clock.
- `a_rst_n` in, 1: reset, asynchronous, active-low.
- `i_sync_rst` in, 1: synchronous soft clear.
- `i_run` in, 1: enable sample issue.
- `i_cfg_we` in, 1: config write strobe.
- `i_cfg_ch` in, `$clog2(N_CH)` (min 1): target channel.
- `i_cfg_sel` in, 2: selects the config target.
  - 0: FCW.
  - 1: phase offset.
  - 2: amplitude (low `AMP_W` bits).
  - 3: accumulator load.
- `i_cfg_data` in, `PHASE_W`: write data.
- `o_valid` out, 1: sample valid.
- `i_ready` in, 1: downstream accept.
- `o_ch` out, `$clog2(N_CH)`: channel tag.
- `o_sample` out, `SIG_W` signed: output sample.

## Operation
- Per-channel state: `acc`, `fcw`, `off`, `amp`. All are 0 after `a_rst_n`.
- Channel counter `ch_q` issues channels round-robin 0..N_CH-1, then wraps to 0.
- Pipeline enable `adv = !(o_valid && !i_ready)`. An issue happens on each edge where `i_run && adv`.
- Stage 0, on issue of channel c:
  - `p0 <= acc[c] + off[c]`, modulo 2^PHASE_W.
  - `acc[c] <= acc[c] + fcw[c]`.
  - `ch0 <= c`, `v0 <= 1`.
  - The phase used is the pre-increment value, so a channel's first sample after clear is at phase `off[c]`.
- Stage 1: `dds_sine_rom` addressed by `p0[PHASE_W-1 -: LUT_AW]`. The ROM output is registered, giving `s1`, `ch1`, `v1`.
- Stage 2:
  - `prod = s1 * {1'b0, amp[ch1]}`, signed, `SIG_W+AMP_W+1` bits.
  - `o_sample <= prod >>> AMP_W`, arithmetic shift, truncated toward −∞.
  - `o_ch <= ch1`, `o_valid <= v1`.
  - `amp` is sampled at stage 2, not at issue.
- When `adv` is 0, all stages hold and `acc`/`ch_q` do not change.
- When `adv` is 1 and there is no issue, `v0` loads 0 and bubbles propagate.
- Config writes take effect on the next edge, regardless of `adv` or `i_run`.
- Write to `fcw`/`off` in the same cycle as an issue of that channel: the issue uses the old value.
- Write with sel 3 in the same cycle as an issue of that channel: the load wins (`acc[c] <= i_cfg_data`), and the issue uses the old `acc` for `p0`.
- `i_run` falling: issue stops, in-flight samples drain, `ch_q` holds.
- `i_run` rising: issue resumes at `ch_q`.
- `i_sync_rst` has priority over every other action. It:
  - clears all `acc`, `ch_q`, stage valids/data, `o_valid`, `o_ch` and `o_sample`;
  - keeps `fcw`, `off` and `amp`;
  - ignores a same-cycle config write.

## Timing
- Reset values: `o_valid`=0, `o_ch`=0, `o_sample`=0.
- Latency: a sample issued at edge k is on the outputs (`o_valid`=1) after edge k+2 when no stall occurs.
- Throughput: one sample per clock. Each channel updates every N_CH clocks while running without stall.
- Output handshake: `o_valid`/`o_sample`/`o_ch` stay stable while `o_valid && !i_ready`. The transfer occurs on an edge with both high. Samples are never dropped or duplicated.
- Async reset can assert mid-stream. Outputs go to their reset values immediately, with no partial sample.

## Structure
- Package `dds_pkg` holds:
  - the `cfg_sel_e` enum: FCW, OFFSET, AMP, ACC_LOAD;
  - the `sine_val(k, LUT_AW, SIG_W)` function: `round(sin(2πk/2^LUT_AW)·(2^(SIG_W-1)−1))`.
- Sub-module `dds_sine_rom`:
  - quarter-wave table of 2^(LUT_AW−2)+1 entries (endpoint included);
  - quadrant mirror/negate logic;
  - registered output, 1-cycle latency.
- Everything else lives in `dds_mc`.

## Test plan
- Reset / zero config: release `a_rst_n`, `i_run`=1, `i_ready`=1.
  - Required: outputs 0 while in reset.
  - Then `o_valid` high from the 2nd edge, `o_ch` 0,1,2,3,0…, `o_sample` all 0 (amp=0).
- Quarter-turn tone: ch0 `fcw`=2^22, `amp`=0xFFFF, defaults elsewhere.
  - Required: ch0 samples are 0, 32766, 0, −32767, repeating, every 4th valid output.
- Phase offset: ch1 `fcw`=0, `off`=2^22, `amp`=0x8000.
  - Required: every ch1 sample is 16383.
- Backpressure: drop `i_ready` for 5 cycles mid-stream.
  - Required: outputs frozen during the stall, no gaps or repeats in per-channel sequence.
  - Required: `acc` advances only on issues.
- Soft clear mid-stream: pulse `i_sync_rst`.
  - Required: `o_valid`=0 after the next edge, `fcw`/`off`/`amp` retained.
  - Required: the sequence restarts at ch0 with phase `off`.
- Collision: write sel 3 (value 2^23) to ch2 on the cycle ch2 issues.
  - Required: that sample uses the old `acc`.
  - Required: the next ch2 sample uses phase 2^23+`off`, i.e. the table value at half-turn, then continues.
